tick_scheduler: RTL and testbench
=================================

// Module: tick_scheduler
// PURPOSE
//   Sequences a free-running prescale counter and schedules NCH single-cycle enable ticks from selectable counter taps.
//   A run/pause/step FSM gates the counter.
//   Ticks replace raw divider bits as clocks: scoreboard display scan, debounce, and score timers run on clk and are qualified by tick[i].
// PARAMETERS
//   WIDTH  32  prescale counter width
//   NCH    4   number of tick channels
//   SELW   5   tap-select width; sel >= WIDTH disables the channel
// PORTS
//   clk      in   1          system clock, all state on posedge
//   rst_n    in   1          asynchronous, active-low reset
//   run      in   1          level: 1 = count continuously
//   step     in   1          1-cycle pulse: single increment while not running
//   clr      in   1          synchronous clear of counter/FSM/ticks
//   cfg_we   in   1          write tap select for channel cfg_ch
//   cfg_ch   in   clog2(NCH) channel index (out-of-range index: write ignored)
//   cfg_sel  in   SELW       tap bit index for that channel
//   cnt      out  WIDTH      current counter value
//   state    out  2          FSM state code
//   tick     out  NCH        per-channel 1-cycle enable pulses
// BEHAVIOUR
//   Reset (rst_n=0, async):
//     cnt=0, state=IDLE, tick=0, sel[i]=i (clamped to WIDTH-1).
//   FSM: IDLE=00, RUN=01, PAUSE=10, STEP=11; priority clr > run > step.
//     IDLE : run -> RUN; else step -> STEP; else stay.
//     RUN  : increment every cycle; run=0 -> PAUSE (no increment that cycle).
//     PAUSE: hold cnt; run -> RUN; else step -> STEP.
//     STEP : exactly one increment on the transition edge into STEP; next state PAUSE (or RUN if run=1).
//       step while in STEP is ignored.
//   inc = increment is applied at this edge (RUN&run, or entering STEP).
//   clr: next edge cnt=0, tick=0, state=IDLE; sel registers kept; overrides run/step same cycle.
//   Counter: cnt <= cnt + 1 modulo 2^WIDTH when inc.
//     Wrap all-ones -> 0 is silent: no bit rises, no tick.
//   Tick:
//     tick[i] is registered on the same edge as the counter update.
//     tick[i] is high for exactly the one cycle in which cnt first shows bit sel[i] = 1 after being 0.
//     i.e. tick[i] <= inc & ~cnt[sel[i]] & cnt_next[sel[i]].
//     Period 2^(sel+1) increments in RUN; first tick when cnt becomes 2^sel.
//     Ticks never fire without an increment (PAUSE/IDLE hold => tick=0).
//     sel[i] >= WIDTH: tick[i] stays 0.
//   Config: cfg_we updates sel[cfg_ch] at the edge.
//     Tick computed at that same edge uses the OLD sel; the new sel applies from the following edge.
//     cfg_we is honoured in every state, including during clr.
//   Outputs are all registered; no combinational path from inputs to outputs.
// CONFIGURATION
//   TICK_SCHED_IRQ_EN defined:
//     Adds ports irq (out, NCH) and irq_ack (in, NCH).
//     irq[i] is set the cycle after tick[i]=1 and is sticky until irq_ack[i]=1 clears it at an edge.
//     Simultaneous set and ack: set wins.
//     rst_n and clr clear irq to 0.
//   TICK_SCHED_IRQ_EN undefined: ports absent; no irq registers.
// TESTING
//   1. Reset mid-count (cnt=0x1234, RUN), rst_n low -> cnt=0, tick=0, state=00 immediately; sel[0..3]=0,1,2,3.
//   2. Defaults, run=1 for 16 cycles:
//      tick[0] at cnt=1,3,5..; tick[1] at cnt=2,6,10,14; tick[3] only at cnt=8.
//      Each tick is 1 cycle wide.
//   3. Pause/step. RUN to cnt=5, run=0 -> state 10, cnt holds 5, tick=0 for 10 cycles.
//      step -> cnt=6, tick[1]=1, state 11 then 10.
//      step again -> cnt=7, tick[0]=1.
//   4. Config. cfg_we ch2 sel=4 at cnt=3 -> no tick[2] at cnt=4, tick[2] at cnt=16.
//      cfg_sel=31 on WIDTH=32 -> tick only at cnt=0x80000000.
//      cfg_sel=40 -> tick[ch]=0 forever.
//   5. Wrap and clr. Preload path via run from 0xFFFFFFFE (force in bench) -> 0xFFFFFFFF ticks ch0, 0x00000000 no tick.
//      clr with run=1 -> cnt=0, state=00, tick=0; run still 1 -> RUN next cycle.
//   6. IRQ (TICK_SCHED_IRQ_EN): tick[1] -> irq[1]=1 next cycle, held; irq_ack[1] -> 0.
//      ack coincident with new tick[1] -> irq[1] stays 1.

Source files
------------

// File: rtl/tick_scheduler.sv
// tick_scheduler: run/pause/step gated prescale counter that schedules NCH
// single-cycle enable ticks from per-channel selectable counter taps.
// Optional feature macro: TICK_SCHED_IRQ_EN adds sticky per-channel irq with irq_ack.

module tick_channel #(
    parameter int WIDTH   = 32,
    parameter int SELW    = 5,
    parameter int SEL_RST = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic             cfg_wr,
    input  logic [SELW-1:0]  cfg_sel,
    input  logic [WIDTH-1:0] cnt,
    input  logic [WIDTH-1:0] cnt_next,
`ifdef TICK_SCHED_IRQ_EN
    input  logic             irq_ack,
    output logic             irq,
`endif
    output logic             tick
);
    logic [SELW-1:0]  sel;
    logic [WIDTH-1:0] tap;
    logic             rise;

    // One-hot tap mask; a select past the top bit shifts the 1 out, so the
    // channel goes silent without any range compare.
    assign tap  = WIDTH'(1) << sel;
    // Selected bit goes 0 -> 1 across this edge; wrap to zero never qualifies.
    assign rise = |(tap & ~cnt & cnt_next);

    // Tap select; a write lands after this edge's tick has used the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      sel <= SELW'(SEL_RST);
        else if (cfg_wr) sel <= cfg_sel;
    end

    // Tick pulse, registered alongside the counter update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tick <= 1'b0;
        else        tick <= inc & rise & ~clr;
    end

`ifdef TICK_SCHED_IRQ_EN
    // Sticky irq: set the cycle after a tick, ack clears, set beats ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       irq <= 1'b0;
        else if (clr)     irq <= 1'b0;
        else if (tick)    irq <= 1'b1;
        else if (irq_ack) irq <= 1'b0;
    end
`endif
endmodule

module tick_scheduler #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int SELW  = 5
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 run,
    input  logic                                 step,
    input  logic                                 clr,
    input  logic                                 cfg_we,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
    input  logic [SELW-1:0]                      cfg_sel,
    output logic [WIDTH-1:0]                     cnt,
    output logic [1:0]                           state,
    output logic [NCH-1:0]                       tick
`ifdef TICK_SCHED_IRQ_EN
    ,
    input  logic [NCH-1:0]                       irq_ack,
    output logic [NCH-1:0]                       irq
`endif
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_STEP  = 2'b11
    } state_t;

    state_t           st, st_nxt;
    logic             inc;
    logic [WIDTH-1:0] cnt_q, cnt_next;

    // Next state and increment qualifier; clr > run > step.
    always_comb begin
        st_nxt = st;
        inc    = 1'b0;
        if (clr) begin
            st_nxt = S_IDLE;
        end else begin
            case (st)
                S_IDLE, S_PAUSE: begin
                    if (run) begin
                        st_nxt = S_RUN;
                    end else if (step) begin
                        st_nxt = S_STEP;
                        inc    = 1'b1;
                    end
                end
                S_RUN: begin
                    if (run) inc = 1'b1;
                    else     st_nxt = S_PAUSE;
                end
                S_STEP:  st_nxt = run ? S_RUN : S_PAUSE;
                default: st_nxt = S_IDLE;
            endcase
        end
    end

    assign cnt_next = clr ? '0 : (inc ? cnt_q + WIDTH'(1) : cnt_q);

    // FSM state and prescale counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st    <= S_IDLE;
            cnt_q <= '0;
        end else begin
            st    <= st_nxt;
            cnt_q <= cnt_next;
        end
    end

    assign cnt   = cnt_q;
    assign state = st;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        localparam int SR = (i < WIDTH) ? i : WIDTH - 1;
        tick_channel #(
            .WIDTH  (WIDTH),
            .SELW   (SELW),
            .SEL_RST(SR)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr     (clr),
            .inc     (inc),
            .cfg_wr  (cfg_we && (cfg_ch == CHW'(i))),
            .cfg_sel (cfg_sel),
            .cnt     (cnt_q),
            .cnt_next(cnt_next),
`ifdef TICK_SCHED_IRQ_EN
            .irq_ack (irq_ack[i]),
            .irq     (irq[i]),
`endif
            .tick    (tick[i])
        );
    end
endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler: directed vector table, hand-written corner
// sequences (tap config, wrap, async reset, irq) and randomized traffic
// checked against an arithmetic reference model.
// SELW is widened to 6 so tap selects beyond the counter width are reachable.

module tb_tick_scheduler;
    localparam int WIDTH = 32;
    localparam int NCH   = 4;
    localparam int SELW  = 6;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             run = 1'b0, step = 1'b0, clr = 1'b0, cfg_we = 1'b0;
    logic [1:0]       cfg_ch = 2'd0;
    logic [SELW-1:0]  cfg_sel = '0;
    logic [WIDTH-1:0] cnt;
    logic [1:0]       state;
    logic [NCH-1:0]   tick;
`ifdef TICK_SCHED_IRQ_EN
    logic [NCH-1:0]   irq_ack = '0;
    logic [NCH-1:0]   irq;
`endif

    always #5 clk = ~clk;

    tick_scheduler #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (run),
        .step   (step),
        .clr    (clr),
        .cfg_we (cfg_we),
        .cfg_ch (cfg_ch),
        .cfg_sel(cfg_sel),
        .cnt    (cnt),
        .state  (state),
        .tick   (tick)
`ifdef TICK_SCHED_IRQ_EN
        ,
        .irq_ack(irq_ack),
        .irq    (irq)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void check(string name, longint act, longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Reference model: counter value, state code, tap per channel, pulses.
    bit [31:0]      m_cnt;
    int             m_state;
    int             m_sel[NCH];
    bit [NCH-1:0]   m_tick;
    bit [NCH-1:0]   m_irq;

    task automatic model_reset();
        m_cnt   = 0;
        m_state = 0;
        for (int i = 0; i < NCH; i++) m_sel[i] = i;
        m_tick  = '0;
        m_irq   = '0;
    endtask

    task automatic model_edge();
        bit        inc = 1'b0;
        int        ns  = m_state;
        bit [31:0] nc;
        if (clr) ns = 0;
        else begin
            case (m_state)
                0, 2: if (run) ns = 1; else if (step) begin ns = 3; inc = 1'b1; end
                1:    if (run) inc = 1'b1; else ns = 2;
                default: ns = run ? 1 : 2;
            endcase
        end
        nc = clr ? 32'd0 : m_cnt + 32'(inc);
`ifdef TICK_SCHED_IRQ_EN
        for (int i = 0; i < NCH; i++)
            m_irq[i] = clr ? 1'b0 : (m_tick[i] | (m_irq[i] & ~irq_ack[i]));
`endif
        for (int i = 0; i < NCH; i++) begin
            longint unsigned half;
            m_tick[i] = 1'b0;
            if (inc && m_sel[i] < WIDTH) begin
                // bit sel rises exactly when the new value sits at 2^sel within its 2^(sel+1) period
                half = 64'd1 << m_sel[i];
                m_tick[i] = ((longint'(nc) % (half * 2)) == half);
            end
        end
        if (cfg_we && int'(cfg_ch) < NCH) m_sel[cfg_ch] = int'(cfg_sel);
        m_cnt   = nc;
        m_state = ns;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("cnt", cnt, m_cnt);
        check("state", state, m_state);
        check("tick", tick, m_tick);
`ifdef TICK_SCHED_IRQ_EN
        check("irq", irq, m_irq);
`endif
    endtask

    task automatic preload(input bit [31:0] v);
        m_cnt = v;
        force dut.cnt_q = v;
        cycle();
        release dut.cnt_q;
    endtask

    typedef struct {
        int run, step, clr, we, ch, sel;
        int cnt_e, st_e, tk_e;
    } vec_t;

    localparam int NV = 30;
    vec_t vt[NV];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, t2, t3, found;

        // run step clr we ch sel | cnt state tick
        vt[0]  = '{1,0,0,0,0,0,  0,1,4'b0000};
        vt[1]  = '{1,0,0,0,0,0,  1,1,4'b0001};
        vt[2]  = '{1,0,0,0,0,0,  2,1,4'b0010};
        vt[3]  = '{1,0,0,0,0,0,  3,1,4'b0001};
        vt[4]  = '{1,0,0,0,0,0,  4,1,4'b0100};
        vt[5]  = '{1,0,0,0,0,0,  5,1,4'b0001};
        vt[6]  = '{0,0,0,0,0,0,  5,2,4'b0000};
        vt[7]  = '{0,0,0,0,0,0,  5,2,4'b0000};
        vt[8]  = '{0,1,0,0,0,0,  6,3,4'b0010};
        vt[9]  = '{0,1,0,0,0,0,  6,2,4'b0000};
        vt[10] = '{0,1,0,0,0,0,  7,3,4'b0001};
        vt[11] = '{0,0,0,0,0,0,  7,2,4'b0000};
        vt[12] = '{1,0,0,0,0,0,  7,1,4'b0000};
        vt[13] = '{1,0,0,0,0,0,  8,1,4'b1000};
        vt[14] = '{1,0,1,0,0,0,  0,0,4'b0000};
        vt[15] = '{1,0,0,0,0,0,  0,1,4'b0000};
        vt[16] = '{1,0,0,0,0,0,  1,1,4'b0001};
        vt[17] = '{1,0,0,0,0,0,  2,1,4'b0010};
        vt[18] = '{1,0,0,1,2,4,  3,1,4'b0001};
        vt[19] = '{1,0,0,0,0,0,  4,1,4'b0000};
        vt[20] = '{1,0,0,1,0,5,  5,1,4'b0001};
        vt[21] = '{1,0,0,0,0,0,  6,1,4'b0010};
        vt[22] = '{0,0,1,1,0,0,  0,0,4'b0000};
        vt[23] = '{1,0,0,0,0,0,  0,1,4'b0000};
        vt[24] = '{1,0,0,0,0,0,  1,1,4'b0001};
        vt[25] = '{1,0,0,0,0,0,  2,1,4'b0010};
        vt[26] = '{0,0,1,0,0,0,  0,0,4'b0000};
        vt[27] = '{0,1,0,0,0,0,  1,3,4'b0001};
        vt[28] = '{1,0,0,0,0,0,  1,1,4'b0000};
        vt[29] = '{1,0,0,0,0,0,  2,1,4'b0010};

        // Power-on reset
        #1 rst_n = 1'b0;
        #7;
        check("rst_cnt", cnt, 0);
        check("rst_state", state, 0);
        check("rst_tick", tick, 0);
        #4 rst_n = 1'b1;
        model_reset();

        // Directed vector table
        for (int r = 0; r < NV; r++) begin
            run     = 1'(vt[r].run);
            step    = 1'(vt[r].step);
            clr     = 1'(vt[r].clr);
            cfg_we  = 1'(vt[r].we);
            cfg_ch  = 2'(vt[r].ch);
            cfg_sel = SELW'(vt[r].sel);
            cycle();
            check($sformatf("vec%0d_cnt", r), cnt, vt[r].cnt_e);
            check($sformatf("vec%0d_state", r), state, vt[r].st_e);
            check($sformatf("vec%0d_tick", r), tick, vt[r].tk_e);
        end
        run = 0; step = 0; clr = 0; cfg_we = 0;

        // Top tap and out-of-range tap
        cycle();
        cfg_we = 1; cfg_ch = 2'd3; cfg_sel = 6'd31; cycle();
        cfg_ch = 2'd2; cfg_sel = 6'd40; cycle();
        cfg_we = 0;
        preload(32'h7FFF_FFF0);
        run = 1; t2 = 0; t3 = 0;
        for (int k = 0; k < 25; k++) begin
            cycle();
            if (tick[3]) begin
                t3++;
                check("sel31_at", cnt, 32'h8000_0000);
            end
            t2 += int'(tick[2]);
        end
        check("sel31_count", t3, 1);
        check("sel40_count", t2, 0);

        // Silent wrap
        run = 0; cycle();
        preload(32'hFFFF_FFFE);
        run = 1; cycle();
        cycle();
        check("wrap_ff_cnt", cnt, 32'hFFFF_FFFF);
        check("wrap_ff_tick", tick, 4'b0001);
        cycle();
        check("wrap_0_cnt", cnt, 0);
        check("wrap_0_tick", tick, 0);

        // Async reset mid-count
        run = 0; cycle();
        preload(32'h0000_1234);
        run = 1; cycle(); cycle();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_cnt", cnt, 0);
        check("midrst_state", state, 0);
        check("midrst_tick", tick, 0);
`ifdef TICK_SCHED_IRQ_EN
        check("midrst_irq", irq, 0);
`endif
        model_reset();
        run = 0;
        #3 rst_n = 1'b1;

        // Default taps after reset, 16 increments
        run = 1; cycle();
        t0 = 0; t1 = 0; t3 = 0;
        for (int k = 0; k < 16; k++) begin
            cycle();
            t0 += int'(tick[0]);
            t1 += int'(tick[1]);
            t3 += int'(tick[3]);
        end
        check("dflt_tick0", t0, 8);
        check("dflt_tick1", t1, 4);
        check("dflt_tick3", t3, 1);

`ifdef TICK_SCHED_IRQ_EN
        // Sticky irq, ack, and set-beats-ack
        clr = 1; run = 0; cycle();
        clr = 0; run = 1; found = 0;
        for (int k = 0; k < 12 && found == 0; k++) begin
            cycle();
            if (tick[1]) found = 1;
        end
        check("irq_wait1", found, 1);
        cycle();
        check("irq_set", irq[1], 1);
        run = 0;
        repeat (3) cycle();
        check("irq_sticky", irq[1], 1);
        irq_ack = 4'b0010; cycle();
        check("irq_acked", irq[1], 0);
        irq_ack = '0; run = 1; found = 0;
        for (int k = 0; k < 12 && found == 0; k++) begin
            cycle();
            if (tick[1]) found = 1;
        end
        check("irq_wait2", found, 1);
        irq_ack = 4'b0010; cycle();
        check("irq_set_wins", irq[1], 1);
        irq_ack = '0;
`endif

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            run     = ($urandom_range(0, 9) < 6);
            step    = ($urandom_range(0, 3) == 0);
            clr     = ($urandom_range(0, 63) == 0);
            cfg_we  = ($urandom_range(0, 15) == 0);
            cfg_ch  = 2'($urandom_range(0, 3));
            cfg_sel = SELW'(($urandom_range(0, 7) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 5));
`ifdef TICK_SCHED_IRQ_EN
            irq_ack = NCH'($urandom);
`endif
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
